// File: rtl/gray_to_rgb_packer.sv
// rtl/gray_to_rgb_packer.sv - 8-bit gray to RGB555 packer with output FIFO; ROUND_EN selects rounding.
module gray_to_rgb_packer #(
    parameter int PIXEL_WIDTH_IN = 8,
    parameter int MAX_PIXEL_BITS = 15,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 20
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      finish_i,
    input  logic [PIXEL_WIDTH_IN-1:0] in_px_gray_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [MAX_PIXEL_BITS-1:0] out_px_rgb_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          px_count_o
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PROCESSING, DRAIN} state_t;

    state_t state, state_next;

    logic [MAX_PIXEL_BITS-1:0] mem_px   [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               count;
    logic                      fifo_full, fifo_empty;
    logic                      push, pop;
    logic [4:0]                c5;

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = in_valid_i & in_ready_o;
    assign pop        = out_valid_o & out_ready_i;

`ifdef ROUND_EN
    logic [8:0] rnd_sum;
    assign rnd_sum = {1'b0, in_px_gray_i[7:0]} + 9'd4;
    assign c5      = rnd_sum[8] ? 5'd31 : rnd_sum[7:3];
`else
    assign c5 = in_px_gray_i[7:3];
`endif

    always_comb begin
        state_next = state;
        in_ready_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = PROCESSING;
            end
            PROCESSING: begin
                // Full blocks input even on a popping cycle: keeps ready off the pop path.
                in_ready_o = !fifo_full;
                if (in_valid_i && !fifo_full && finish_i) state_next = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_px[wr_ptr]   <= {c5, c5, c5};
            mem_last[wr_ptr] <= finish_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            px_count_o <= '0;
        end else if (state == IDLE && start_i) begin
            px_count_o <= '0;
        end else if (push && px_count_o != {CNT_W{1'b1}}) begin
            px_count_o <= px_count_o + 1'b1;
        end
    end

    assign out_valid_o  = !fifo_empty;
    assign out_px_rgb_o = out_valid_o ? mem_px[rd_ptr] : '0;
    assign out_last_o   = out_valid_o ? mem_last[rd_ptr] : 1'b0;
    assign busy_o       = (state != IDLE);
endmodule

// File: tb/tb_gray_to_rgb_packer.sv
// tb/tb_gray_to_rgb_packer.sv - self-checking bench for gray_to_rgb_packer with randomized frames.
module tb_gray_to_rgb_packer;
    logic        clk_i = 1'b0;
    logic        reset_i, start_i, finish_i, in_valid_i, out_ready_i;
    logic [7:0]  in_px_gray_i;
    logic        in_ready_o, out_valid_o, out_last_o, busy_o;
    logic [14:0] out_px_rgb_o;
    logic [19:0] px_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int occ      = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    gray_to_rgb_packer dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .finish_i(finish_i),
        .in_px_gray_i(in_px_gray_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_px_rgb_o(out_px_rgb_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .busy_o(busy_o), .px_count_o(px_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [14:0] conv(input logic [7:0] g);
        int c;
`ifdef ROUND_EN
        c = (int'(g) + 4) / 8;
        if (c > 31) c = 31;
`else
        c = int'(g) / 8;
`endif
        return 15'(c * 1024 + c * 32 + c);
    endfunction

    // Observes both handshakes just before the edge, then advances to the next falling edge.
    task automatic tick();
        if (!reset_i) begin
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back({finish_i, conv(in_px_gray_i)});
                n_acc++;
                occ++;
            end
            if (out_valid_o && out_ready_i) begin
                obs_q.push_back({out_last_o, out_px_rgb_o});
                occ--;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        in_valid_i = 1'b1;
        in_px_gray_i = 8'h55;
        tick();
        n_checks++; if (in_ready_o !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready_o); else n_pass++;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_o); else n_pass++;
        n_checks++; if (px_count_o !== 20'd0) $display("FAIL reset_px_count got %0d want 0", px_count_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (out_px_rgb_o !== 15'h0 || out_last_o !== 1'b0)
            $display("FAIL reset_out_data got %h/%b want 0/0", out_px_rgb_o, out_last_o); else n_pass++;
        in_valid_i = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [7:0]  px[3];
        logic [14:0] want_lit[3];
        bit got;
        px = '{8'h80, 8'hFF, 8'h0C};
`ifdef ROUND_EN
        want_lit = '{15'h4210, 15'h7FFF, 15'h0842};
`else
        want_lit = '{15'h4210, 15'h7FFF, 15'h0421};
`endif
        out_ready_i = 1'b1;
        start_frame();
        n_checks++; if (busy_o !== 1'b1 || px_count_o !== 20'd0)
            $display("FAIL basic_start got busy=%b cnt=%0d want 1/0", busy_o, px_count_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_px_gray_i = px[i];
            finish_i = (i == 2);
            tick();
        end
        in_valid_i = 1'b0;
        finish_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (obs_q.size() > 0 && obs_q[$][15]) got = 1'b1;
        end
        n_checks++; if (!got) $display("FAIL basic_last_pop got none want one within 10 cycles"); else n_pass++;
        n_checks++; if (busy_o !== 1'b1) $display("FAIL basic_busy_at_pop got %b want 1", busy_o); else n_pass++;
        tick();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL basic_busy_drop got %b want 0", busy_o); else n_pass++;
        n_checks++; if (obs_q.size() != 3) $display("FAIL basic_beats got %0d want 3", obs_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== {(i == 2) ? 1'b1 : 1'b0, want_lit[i]} || want_lit[i] !== conv(px[i]))
                $display("FAIL basic_word%0d got %h want %h", i, obs_q[i], {(i == 2) ? 1'b1 : 1'b0, want_lit[i]});
            else n_pass++;
        end
        n_checks++; if (px_count_o !== 20'd3) $display("FAIL basic_px_count got %0d want 3", px_count_o); else n_pass++;
    endtask

    task automatic test_back_pressure();
        int base;
        out_ready_i = 1'b0;
        start_frame();
        base = n_acc;
        for (int i = 0; i < 10 && (n_acc - base) < 4; i++) begin
            in_valid_i = 1'b1;
            in_px_gray_i = 8'(8 * (n_acc - base + 1));
            finish_i = ((n_acc - base) == 5);
            tick();
        end
        n_checks++; if (n_acc - base != 4) $display("FAIL bp_accepts got %0d want 4", n_acc - base); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            in_px_gray_i = 8'(8 * (n_acc - base + 1));
            tick();
            n_checks++; if (in_ready_o !== 1'b0 || n_acc - base != 4)
                $display("FAIL bp_full_ready got %b/%0d want 0/4", in_ready_o, n_acc - base); else n_pass++;
            n_checks++; if (out_px_rgb_o !== 15'h0421 || out_valid_o !== 1'b1)
                $display("FAIL bp_head_stable got %h/%b want 0421/1", out_px_rgb_o, out_valid_o); else n_pass++;
        end
        out_ready_i = 1'b1;
        n_checks++; if (in_ready_o !== 1'b0) $display("FAIL bp_not_pop_aware got %b want 0", in_ready_o); else n_pass++;
        for (int i = 0; i < 30 && ((n_acc - base) < 6 || busy_o); i++) begin
            if ((n_acc - base) < 6) begin
                in_valid_i = 1'b1;
                in_px_gray_i = 8'(8 * (n_acc - base + 1));
                finish_i = ((n_acc - base) == 5);
            end else begin
                in_valid_i = 1'b0;
                finish_i = 1'b0;
            end
            tick();
        end
        in_valid_i = 1'b0;
        finish_i = 1'b0;
        n_checks++; if (obs_q.size() != 6 || busy_o !== 1'b0)
            $display("FAIL bp_beats got %0d busy=%b want 6 busy=0", obs_q.size(), busy_o); else n_pass++;
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== {(i == 5) ? 1'b1 : 1'b0, 15'(1057 * (i + 1))})
                $display("FAIL bp_word%0d got %h want %h", i, obs_q[i], {(i == 5) ? 1'b1 : 1'b0, 15'(1057 * (i + 1))});
            else n_pass++;
        end
    endtask

    task automatic test_edge_cases();
        out_ready_i = 1'b0;
        start_frame();
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_px_gray_i = 8'($urandom);
            tick();
        end
        in_valid_i = 1'b0;
        finish_i = 1'b1;
        tick();
        finish_i = 1'b0;
        n_checks++; if (busy_o !== 1'b1 || in_ready_o !== 1'b1)
            $display("FAIL edge_finish_no_valid got busy=%b ready=%b want 1/1", busy_o, in_ready_o); else n_pass++;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if (px_count_o !== 20'd2) $display("FAIL edge_start_in_proc got %0d want 2", px_count_o); else n_pass++;
        in_valid_i = 1'b1;
        in_px_gray_i = 8'($urandom);
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1 || occ != 3)
            $display("FAIL edge_buffered got valid=%b occ=%0d want 1/3", out_valid_o, occ); else n_pass++;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        occ = 0;
        exp_q.delete();
        obs_q.delete();
        n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || px_count_o !== 20'd0 || in_ready_o !== 1'b0)
            $display("FAIL edge_mid_reset got valid=%b busy=%b cnt=%0d ready=%b want 0/0/0/0",
                     out_valid_o, busy_o, px_count_o, in_ready_o); else n_pass++;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (obs_q.size() != 0) $display("FAIL edge_post_reset_beats got %0d want 0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_conversion();
        logic [7:0]  px[4];
        logic [14:0] want[4];
        px = '{8'h0C, 8'hFF, 8'h03, 8'h04};
`ifdef ROUND_EN
        want = '{15'h0842, 15'h7FFF, 15'h0000, 15'h0421};
`else
        want = '{15'h0421, 15'h7FFF, 15'h0000, 15'h0000};
`endif
        out_ready_i = 1'b1;
        start_frame();
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_px_gray_i = px[i];
            finish_i = (i == 3);
            tick();
        end
        in_valid_i = 1'b0;
        finish_i = 1'b0;
        for (int i = 0; i < 10 && busy_o; i++) tick();
        n_checks++; if (obs_q.size() != 4) $display("FAIL conv_beats got %0d want 4", obs_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i][14:0] !== want[i]) $display("FAIL conv_px%0d got %h want %h", i, obs_q[i][14:0], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        int base, len, lasts;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 10);
            out_ready_i = 1'b0;
            start_frame();
            base = n_acc;
            for (int cyc = 0; cyc < 300 && ((n_acc - base) < len || busy_o); cyc++) begin
                n_checks++;
                if (in_ready_o !== (((n_acc - base) < len) && occ < 4))
                    $display("FAIL rand_in_ready frame %0d got %b want %b", f, in_ready_o, ((n_acc - base) < len) && occ < 4);
                else n_pass++;
                in_valid_i = ((n_acc - base) < len) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_px_gray_i = 8'($urandom);
                finish_i = in_valid_i && ((n_acc - base) == len - 1);
                out_ready_i = 1'($urandom_range(0, 2) != 0);
                tick();
            end
            in_valid_i = 1'b0;
            finish_i = 1'b0;
            lasts = 0;
            foreach (obs_q[i]) lasts += int'(obs_q[i][15]);
            n_checks++; if (obs_q.size() != len || busy_o !== 1'b0)
                $display("FAIL rand_beats frame %0d got %0d busy=%b want %0d busy=0", f, obs_q.size(), busy_o, len); else n_pass++;
            n_checks++; if (obs_q != exp_q) $display("FAIL rand_order frame %0d got %0d words want %0d matching", f, obs_q.size(), exp_q.size()); else n_pass++;
            n_checks++; if (lasts != 1 || (obs_q.size() > 0 && obs_q[$][15] !== 1'b1))
                $display("FAIL rand_last frame %0d got %0d last beats want 1 at end", f, lasts); else n_pass++;
            n_checks++; if (px_count_o !== 20'(len)) $display("FAIL rand_px_count frame %0d got %0d want %0d", f, px_count_o, len); else n_pass++;
        end
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        finish_i = 1'b0;
        in_valid_i = 1'b0;
        in_px_gray_i = 8'h00;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_edge_cases();
        test_conversion();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gray_to_rgb_packer.md
Name: gray_to_rgb_packer

Overview:
- Back-end converter for the grayscale/Sobel pipeline: takes 8-bit gray (or Sobel magnitude) pixels and re-expands each to an RGB555 word for the display/frame-buffer writer.
- Uses the same start_i/finish_i frame framing as the RGB-to-gray front end, plus valid/ready handshakes on both sides.
- A small FIFO absorbs downstream back-pressure.
- An FSM tracks the frame and drains the FIFO after the last pixel.

Parameters:
- PIXEL_WIDTH_IN, 8, gray input width (fixed at 8; other values unsupported).
- MAX_PIXEL_BITS, 15, RGB555 output width (3 x 5 bits).
- FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 2.
- CNT_W, 20, width of the accepted-pixel counter.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  frame start pulse; honoured only in IDLE.
- finish_i  input  1  last-pixel marker; qualified by an input handshake.
- in_px_gray_i  input  8  gray pixel.
- in_valid_i  input  1  in_px_gray_i valid.
- in_ready_o  output  1  block can accept a pixel this cycle.
- out_px_rgb_o  output  15  {R[14:10], G[9:5], B[4:0]}.
- out_valid_o  output  1  out_px_rgb_o valid.
- out_ready_i  input  1  downstream accepts.
- out_last_o  output  1  current output beat is the last pixel of the frame.
- busy_o  output  1  FSM not in IDLE.
- px_count_o  output  CNT_W  pixels accepted in the current or most recent frame.

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE and FIFO emptied. All outputs 0: in_ready_o, out_valid_o, out_px_rgb_o, out_last_o, busy_o, px_count_o.
  - Reset asserted mid-frame discards all buffered pixels with no further output beats.
- FSM states: IDLE, PROCESSING, DRAIN.
  - IDLE: in_ready_o=0. start_i=1 -> PROCESSING next cycle and px_count_o cleared to 0 on that edge.
  - PROCESSING: in_ready_o = !fifo_full, which is not pop-aware, so a full FIFO blocks input even when popping that cycle. An accepted beat with finish_i=1 -> DRAIN. finish_i without an accepted beat is ignored.
  - DRAIN: in_ready_o=0. When the FIFO is empty and no pop is pending -> IDLE.
  - start_i is ignored outside IDLE. start_i and finish_i together in IDLE: start is taken, finish ignored.
- Input handshake: a beat is accepted when in_valid_i & in_ready_o on a rising edge.
  - The accepted pixel is converted and pushed with a last flag equal to finish_i.
  - px_count_o increments per accepted beat and saturates at 2^CNT_W-1.
- Conversion (default): c5 = in_px_gray_i[7:3]; out word = {c5, c5, c5}.
- Output handshake:
  - out_valid_o = FIFO non-empty. out_px_rgb_o and out_last_o come from the FIFO head register.
  - Pop when out_valid_o & out_ready_i.
  - out_px_rgb_o and out_last_o are 0 when out_valid_o=0.
  - Head data and flag stay stable while out_valid_o=1 and out_ready_i=0.
- Latency: a pixel accepted at edge N gives out_valid_o=1 from edge N+1 if the FIFO was empty. Throughput is 1 pixel/cycle while out_ready_i=1.
- FIFO boundaries:
  - Simultaneous push/pop with the FIFO neither empty nor full: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: an empty FIFO never forwards combinationally.
- busy_o = (state != IDLE). It drops the cycle after the last-flagged beat is popped.
- Exactly one out_last_o beat per frame.

Optional Feature:
- Macro ROUND_EN.
- Defined: c5 = min(31, (in_px_gray_i + 4) >> 3), computed 9 bits wide and saturated. Latency unchanged.
- Undefined: truncation, c5 = in_px_gray_i[7:3].

Test Plan:
- Reset/idle: hold reset_i 2 cycles, then drive in_valid_i=1 with no start_i -> in_ready_o=0, out_valid_o=0, px_count_o=0, busy_o=0.
- Basic frame: start_i, then gray 0x80, 0xFF, 0x0C (finish_i on the third beat), out_ready_i=1.
  - Outputs 0x4210, 0x7FFF, 0x0421; out_last_o only on 0x0421.
  - px_count_o=3; busy_o low 1 cycle after the last pop.
- Back-pressure: out_ready_i=0, stream 6 pixels 0x08..0x30 step 8.
  - in_ready_o drops after 4 accepts; head stays 0x0421.
  - Release out_ready_i -> all 6 words 0x0421, 0x0842, ... 0x18C6 in order, none lost or duplicated.
- Edge cases:
  - finish_i with in_valid_i=0 -> no state change.
  - start_i during PROCESSING -> px_count_o not cleared.
  - Mid-frame reset_i with 3 words buffered -> out_valid_o=0 next cycle, FIFO empty.
- ROUND_EN build:
  - 0x0C -> 0x0842; 0xFF -> 0x7FFF (saturated); 0x03 -> 0x0000; 0x04 -> 0x0421.
